// File: rtl/uart_pkg.sv
// Shared types and frame constants for the 8N1 UART transmitter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/uart_if.sv
// Parallel-side and serial-side signals of the UART transmitter.
interface uart_if;

  logic       load_byte;
  logic       t_byte;
  logic [7:0] data;
  logic       serial_out;
  logic       busy;

  modport master (
    output load_byte, t_byte, data,
    input  serial_out, busy
  );

  modport slave (
    input  load_byte, t_byte, data,
    output serial_out, busy
  );

endinterface

// File: rtl/uart_baud_gen.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled and flags the last count.
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_bit_tick
);

  localparam logic [7:0] LAST_COUNT = 8'(CLKS_PER_BIT - 1);

  logic [7:0] r_count;
  logic       w_last;

  assign w_last     = (r_count == LAST_COUNT);
  assign o_bit_tick = i_enable && w_last;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_last ? 8'd0 : r_count + 8'd1;
    end
  end

endmodule

// File: rtl/uart.sv
// 8N1 UART transmitter: holding register, shift register and frame FSM.
module uart
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic   clk,
  input  logic   rst,
  uart_if.slave  bus
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e r_state;
  logic [7:0]  r_hold;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_idx;
  logic        r_serial;
  logic        r_busy;

  logic        w_bit_tick;
  logic        w_baud_clear;
  logic        w_baud_en;
  logic [7:0]  w_tx_byte;

  assign w_baud_clear = (r_state == IDLE);
  assign w_baud_en    = !w_baud_clear;
  // A same-edge load bypasses the holding register so the new byte goes out.
  assign w_tx_byte    = bus.load_byte ? bus.data : r_hold;

  uart_baud_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud_gen (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_baud_clear),
    .i_enable   (w_baud_en),
    .o_bit_tick (w_bit_tick)
  );

  // NOTE: serial_out/busy are updated here alongside the state, so neither has a path from an input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_hold    <= '0;
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_serial  <= 1'b1;
      r_busy    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_serial <= 1'b1;
          r_busy   <= 1'b0;
          if (bus.load_byte) r_hold <= bus.data;
          if (bus.t_byte) begin
            r_state   <= START;
            r_shift   <= w_tx_byte;
            r_bit_idx <= '0;
            r_serial  <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        START: begin
          if (w_bit_tick) begin
            r_state  <= DATA;
            r_serial <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_tick) begin
            if (r_bit_idx == LAST_BIT) begin
              r_state  <= STOP;
              r_serial <= 1'b1;
            end else begin
              r_shift   <= r_shift >> 1;
              r_serial  <= r_shift[1];
              r_bit_idx <= r_bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (w_bit_tick) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.serial_out = r_serial;
  assign bus.busy       = r_busy;

endmodule

// File: tb/tb_uart.sv
// Randomised and directed bench for the UART transmitter against a frame-level model.
module tb_uart;

  localparam int CPB       = 4;
  localparam int FRAME_LEN = 10 * CPB;

  logic clk;
  logic rst;

  uart_if u_if ();

  uart #(
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is a 10-bit vector held for CPB cycles per bit.
  logic [7:0] m_hold;
  logic [9:0] m_frame;
  int         m_pos;
  bit         m_active;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_hold   = 8'h00;
      m_active = 1'b0;
      m_pos    = 0;
      m_frame  = 10'h3FF;
    end else if (!m_active) begin
      if (u_if.load_byte) m_hold = u_if.data;
      if (u_if.t_byte) begin
        m_frame  = {1'b1, m_hold, 1'b0};
        m_active = 1'b1;
        m_pos    = 0;
      end
    end else begin
      m_pos++;
      if (m_pos == FRAME_LEN) m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic exp_serial;
    exp_serial = m_active ? m_frame[m_pos / CPB] : 1'b1;
    check("line{busy,serial}", {30'd0, u_if.busy, u_if.serial_out},
          {30'd0, m_active, exp_serial});
  end

  // Starts a frame at the current negedge and samples each bit mid-period.
  task automatic send_frame(input string name, input logic [7:0] d, input bit do_load,
                            input logic [9:0] exp_bits, input bit inject);
    logic [9:0] got;
    int         busy_cnt;
    u_if.load_byte = do_load;
    u_if.data      = d;
    u_if.t_byte    = 1'b1;
    @(negedge clk);
    u_if.load_byte = 1'b0;
    u_if.t_byte    = 1'b0;
    u_if.data      = 8'($urandom);
    got      = '0;
    busy_cnt = 0;
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c > 0) @(negedge clk);
      if (u_if.busy) busy_cnt++;
      if (c % CPB == 1) got[c / CPB] = u_if.serial_out;
      if (inject && c == 10) begin
        u_if.load_byte = 1'b1;
        u_if.data      = 8'h3C;
        u_if.t_byte    = 1'b1;
      end
      if (inject && c == 11) begin
        u_if.load_byte = 1'b0;
        u_if.t_byte    = 1'b0;
      end
    end
    @(negedge clk);
    check({name, " bits"}, {22'd0, got}, {22'd0, exp_bits});
    check({name, " busy cycles"}, busy_cnt, FRAME_LEN);
    check({name, " idle after"}, {30'd0, u_if.busy, u_if.serial_out}, 32'd1);
  endtask

  task automatic load_only(input logic [7:0] d);
    u_if.load_byte = 1'b1;
    u_if.data      = d;
    @(negedge clk);
    u_if.load_byte = 1'b0;
    u_if.data      = 8'($urandom);
  endtask

  initial begin
    rst            = 1'b1;
    u_if.load_byte = 1'b0;
    u_if.t_byte    = 1'b0;
    u_if.data      = 8'h00;
    #1 rst = 1'b0;

    // Random strobes under reset must not disturb the idle line.
    repeat (8) begin
      @(negedge clk);
      u_if.load_byte = 1'($urandom);
      u_if.t_byte    = 1'($urandom);
      u_if.data      = 8'($urandom);
    end
    @(negedge clk);
    check("reset serial_out", {31'd0, u_if.serial_out}, 32'd1);
    check("reset busy", {31'd0, u_if.busy}, 32'd0);
    u_if.load_byte = 1'b0;
    u_if.t_byte    = 1'b0;
    rst            = 1'b1;
    @(negedge clk);

    load_only(8'h55);
    send_frame("0x55", 8'hFF, 1'b0, 10'b1010101010, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    load_only(8'h2A);
    send_frame("0x2A", 8'h00, 1'b0, 10'b1001010100, 1'b0);

    load_only(8'h0F);
    send_frame("same-cycle 0xF0", 8'hF0, 1'b1, 10'b1111100000, 1'b0);

    // Back-to-back: busy strobes are ignored and the held 0xA5 goes out twice.
    load_only(8'hA5);
    send_frame("0xA5 with strobes", 8'h00, 1'b0, 10'b1101001010, 1'b1);
    repeat (3) @(negedge clk);
    check("no second frame", {31'd0, u_if.busy}, 32'd0);
    send_frame("0xA5 resend", 8'h3C, 1'b0, 10'b1101001010, 1'b0);
    send_frame("0xA5 back-to-back", 8'h11, 1'b0, 10'b1101001010, 1'b0);

    // Abort during data bit 3 (bit period 4 of the frame).
    u_if.t_byte = 1'b1;
    @(negedge clk);
    u_if.t_byte = 1'b0;
    repeat (17) @(negedge clk);
    check("pre-abort busy", {31'd0, u_if.busy}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("abort serial_out", {31'd0, u_if.serial_out}, 32'd1);
    check("abort busy", {31'd0, u_if.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send_frame("after reset 0x00", 8'hC3, 1'b0, 10'b1000000000, 1'b0);

    repeat (3000) begin
      @(negedge clk);
      u_if.load_byte = ($urandom_range(0, 7) == 0);
      u_if.t_byte    = ($urandom_range(0, 15) == 0);
      u_if.data      = 8'($urandom);
    end
    u_if.load_byte = 1'b0;
    u_if.t_byte    = 1'b0;
    repeat (FRAME_LEN + 2) @(negedge clk);
    check("final idle", {30'd0, u_if.busy, u_if.serial_out}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
